// File: rtl/gpio_pwm_ctrl.sv
// gpio_pwm_ctrl: memory-mapped GPIO controller with PWM channels on the low pins.
// Period/duty writes land in shadow registers and are applied at the period wrap.
// Optional feature macro GPIO_IRQ_EN: builds edge detection, IRQ_EN/IRQ_STAT/IRQ_EDGE
// registers and the irq output; without it those offsets read 0 and irq is tied low.
module gpio_pwm_ctrl #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned PWM_CH = 4,
    parameter int unsigned PWM_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    output logic             response,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    // Channels beyond the pin count have nowhere to drive.
    localparam int unsigned NPIN = (PWM_CH < WIDTH) ? PWM_CH : WIDTH;

    localparam logic [5:0] WordDir     = 6'h00;
    localparam logic [5:0] WordOut     = 6'h01;
    localparam logic [5:0] WordIn      = 6'h02;
    localparam logic [5:0] WordPwmEn   = 6'h03;
    localparam logic [5:0] WordIrqEn   = 6'h04;
    localparam logic [5:0] WordIrqStat = 6'h05;
    localparam logic [5:0] WordRise    = 6'h06;
    localparam logic [5:0] WordFall    = 6'h07;
    localparam logic [5:0] WordPeriod  = 6'h08;
    localparam logic [5:0] WordDuty    = 6'h10;

    logic [5:0]        word;
    logic              wr_en;
    logic              rd_en;
    logic              unused_addr;

    logic [WIDTH-1:0]  dir_q;
    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  sync1_q;
    logic [WIDTH-1:0]  sync2_q;
    logic [PWM_CH-1:0] pwm_en_q;

    logic [PWM_W-1:0]  per_sh_q   [PWM_CH];
    logic [PWM_W-1:0]  duty_sh_q  [PWM_CH];
    logic [PWM_W-1:0]  per_act_q  [PWM_CH];
    logic [PWM_W-1:0]  duty_act_q [PWM_CH];
    logic [PWM_W-1:0]  cnt_q      [PWM_CH];

    logic [PWM_CH-1:0] wrap;
    logic [PWM_CH-1:0] load;
    logic [PWM_CH-1:0] pwm;

    logic [WIDTH-1:0]  pin_o_d;
    logic [WIDTH-1:0]  pin_oe_d;
    logic [31:0]       rd_d;

    logic [31:0]       read_data_q;
    logic              response_q;
    logic [WIDTH-1:0]  gpio_o_q;
    logic [WIDTH-1:0]  gpio_oe_q;

    assign word        = address[7:2];
    assign wr_en       = write;
    // A simultaneous write wins; the read then returns 0.
    assign rd_en       = read & ~write;
    assign unused_addr = ^{address[31:8], address[1:0]};

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] irq_stat_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] sync3_q;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] stat_clr;
    logic             irq_q;

    assign edge_set = (sync2_q & ~sync3_q & rise_q) | (~sync2_q & sync3_q & fall_q);
    assign stat_clr = (wr_en && word == WordIrqStat) ? write_data[WIDTH-1:0] : '0;

    // Interrupt registers; a new edge beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            sync3_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync3_q    <= sync2_q;
            if (wr_en && word == WordIrqEn) irq_en_q <= write_data[WIDTH-1:0];
            if (wr_en && word == WordRise)  rise_q   <= write_data[WIDTH-1:0];
            if (wr_en && word == WordFall)  fall_q   <= write_data[WIDTH-1:0];
            irq_stat_q <= (irq_stat_q & ~stat_clr) | edge_set;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Two-flop input synchroniser.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

    // Bus-writable control registers and period/duty shadows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q    <= '0;
            out_q    <= '0;
            pwm_en_q <= '0;
            for (int c = 0; c < PWM_CH; c++) begin
                per_sh_q[c]  <= '0;
                duty_sh_q[c] <= '0;
            end
        end else if (wr_en) begin
            case (word)
                WordDir:   dir_q    <= write_data[WIDTH-1:0];
                WordOut:   out_q    <= write_data[WIDTH-1:0];
                WordPwmEn: pwm_en_q <= write_data[PWM_CH-1:0];
                default:   ;
            endcase
            for (int c = 0; c < PWM_CH; c++) begin
                if (word == WordPeriod + 6'(c)) per_sh_q[c]  <= write_data[PWM_W-1:0];
                if (word == WordDuty + 6'(c))   duty_sh_q[c] <= write_data[PWM_W-1:0];
            end
        end
    end

    // Per-channel wrap/load decisions and raw PWM level.
    always_comb begin
        for (int c = 0; c < PWM_CH; c++) begin
            wrap[c] = (cnt_q[c] == per_act_q[c] - PWM_W'(1));
            // Idle or zero-period channels track their shadows every cycle.
            load[c] = !pwm_en_q[c] || (per_act_q[c] == '0) || wrap[c];
            pwm[c]  = (per_act_q[c] != '0) && (cnt_q[c] < duty_act_q[c]);
        end
    end

    // PWM counters and active period/duty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < PWM_CH; c++) begin
                per_act_q[c]  <= '0;
                duty_act_q[c] <= '0;
                cnt_q[c]      <= '0;
            end
        end else begin
            for (int c = 0; c < PWM_CH; c++) begin
                if (load[c]) begin
                    per_act_q[c]  <= per_sh_q[c];
                    duty_act_q[c] <= duty_sh_q[c];
                end
                cnt_q[c] <= load[c] ? '0 : cnt_q[c] + PWM_W'(1);
            end
        end
    end

    // Pin mux: enabled PWM channels take over their pin, others follow DIR/OUT.
    always_comb begin
        pin_o_d  = out_q;
        pin_oe_d = dir_q;
        for (int c = 0; c < NPIN; c++) begin
            if (pwm_en_q[c]) begin
                pin_oe_d[c] = 1'b1;
                pin_o_d[c]  = pwm[c];
            end
        end
    end

    // Read mux; unmapped words and unused upper bits return 0.
    always_comb begin
        rd_d = '0;
        case (word)
            WordDir:     rd_d[WIDTH-1:0]  = dir_q;
            WordOut:     rd_d[WIDTH-1:0]  = out_q;
            WordIn:      rd_d[WIDTH-1:0]  = sync2_q;
            WordPwmEn:   rd_d[PWM_CH-1:0] = pwm_en_q;
`ifdef GPIO_IRQ_EN
            WordIrqEn:   rd_d[WIDTH-1:0]  = irq_en_q;
            WordIrqStat: rd_d[WIDTH-1:0]  = irq_stat_q;
            WordRise:    rd_d[WIDTH-1:0]  = rise_q;
            WordFall:    rd_d[WIDTH-1:0]  = fall_q;
`endif
            default:     ;
        endcase
        for (int c = 0; c < PWM_CH; c++) begin
            if (word == WordPeriod + 6'(c)) rd_d[PWM_W-1:0] = per_sh_q[c];
            if (word == WordDuty + 6'(c))   rd_d[PWM_W-1:0] = duty_sh_q[c];
        end
    end

    // Registered bus response and pad outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            response_q  <= 1'b0;
            read_data_q <= '0;
            gpio_o_q    <= '0;
            gpio_oe_q   <= '0;
        end else begin
            response_q  <= read | write;
            read_data_q <= rd_en ? rd_d : '0;
            gpio_o_q    <= pin_o_d;
            gpio_oe_q   <= pin_oe_d;
        end
    end

    assign response  = response_q;
    assign read_data = read_data_q;
    assign gpio_o    = gpio_o_q;
    assign gpio_oe   = gpio_oe_q;

endmodule

// File: tb/tb_gpio_pwm_ctrl.sv
// tb_gpio_pwm_ctrl: directed bench for gpio_pwm_ctrl (default parameters).
module tb_gpio_pwm_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        response;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_data_q[$];
    string       exp_name_q[$];
    int          exp_cyc_q[$];

    gpio_pwm_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read       (read),
        .write      (write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .response   (response),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_oe    (gpio_oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    // Expected response appears after the next rising edge.
    task automatic expect_rsp(input string nm, input logic [31:0] d);
        exp_name_q.push_back(nm);
        exp_data_q.push_back(d);
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        write      = 1'b1;
        address    = {24'h0, a};
        write_data = d;
        expect_rsp($sformatf("wr %02h", a), 32'h0);
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        read    = 1'b1;
        address = {24'h0, a};
        expect_rsp($sformatf("rd %02h", a), exp);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic bus_rw(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        read       = 1'b1;
        write      = 1'b1;
        address    = {24'h0, a};
        write_data = d;
        expect_rsp($sformatf("rw %02h", a), 32'h0);
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Monitor: pops one expectation per response and checks data and latency.
    initial begin : monitor
        string       nm;
        logic [31:0] ed;
        int          ec;
        forever begin
            @(negedge clk);
            if (response === 1'b1) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got response=1, required none");
                end else begin
                    nm = exp_name_q.pop_front();
                    ed = exp_data_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check(nm, read_data, ed);
                    check({nm, " latency"}, 32'(cyc), 32'(ec));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [29:0] got_a, exp_a;
        logic [19:0] got_b, exp_b;
        logic [9:0]  got_c, exp_c;
        logic [11:0] got_k;
        logic        e;
        bit          seen;

        rst_n = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; write_data = '0; gpio_i = '0;
        repeat (3) @(negedge clk);
        check("reset gpio_oe", gpio_oe, 32'h0);
        check("reset gpio_o", gpio_o, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset response", 32'(response), 32'h0);
        check("reset read_data", read_data, 32'h0);
        rst_n = 1'b1;

        // Every offset reads 0 after reset
        for (int a = 0; a <= 'h60; a += 4) bus_rd(a[7:0], 32'h0);

        // DIR/OUT and output latency
        bus_wr(8'h00, 32'h0000_000F);
        bus_wr(8'h04, 32'h0000_0005);
        check("gpio_oe after DIR", gpio_oe, 32'h0000_000F);
        check("gpio_o one cycle after OUT", gpio_o, 32'h0);
        @(negedge clk);
        check("gpio_o after OUT", gpio_o, 32'h0000_0005);

        // Input synchroniser: first read lands before the new value is through
        gpio_i = 32'h0000_00A0;
        bus_rd(8'h08, 32'h0);
        bus_rd(8'h08, 32'h0000_00A0);

        // PWM channel 0: period 10, duty 3, then duty 8 mid-period, then period 0
        bus_wr(8'h00, 32'h0000_000E);
        bus_wr(8'h20, 32'd10);
        bus_wr(8'h40, 32'd3);
        bus_wr(8'h0C, 32'h1);
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            e = (j <= 50) && (((j - 1) % 10) < ((j <= 30) ? 3 : 8));
            if (j <= 30) begin
                got_a[j-1] = gpio_o[0];
                exp_a[j-1] = e;
            end else if (j <= 50) begin
                got_b[j-31] = gpio_o[0];
                exp_b[j-31] = e;
            end else begin
                got_c[j-51] = gpio_o[0];
                exp_c[j-51] = e;
            end
            if (j == 5) check("pwm forces oe over DIR", gpio_oe, 32'h0000_000F);
            if (j == 25) begin
                write = 1'b1; address = 32'h40; write_data = 32'd8;
                expect_rsp("wr duty0=8", 32'h0);
            end
            if (j == 26) write = 1'b0;
            if (j == 45) begin
                write = 1'b1; address = 32'h20; write_data = 32'd0;
                expect_rsp("wr period0=0", 32'h0);
            end
            if (j == 46) write = 1'b0;
        end
        check("pwm 3/10 periods", 32'(got_a), 32'(exp_a));
        check("pwm 8/10 periods", 32'(got_b), 32'(exp_b));
        check("pwm period 0 low", 32'(got_c), 32'(exp_c));

        // Duty above period -> constant high
        bus_wr(8'h40, 32'd12);
        bus_wr(8'h20, 32'd10);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            got_k[k] = gpio_o[0];
        end
        check("pwm duty>=period high", 32'(got_k), 32'h0000_0FFF);

        // Duty 0 -> constant low once the period wraps
        bus_wr(8'h40, 32'd0);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            got_k[k] = gpio_o[0];
        end
        check("pwm duty 0 low", 32'(got_k), 32'h0);

        // Disable -> pin reverts to DIR/OUT one cycle later
        bus_wr(8'h0C, 32'h0);
        check("disable oe latency", gpio_oe, 32'h0000_000F);
        check("disable o latency", gpio_o, 32'h0000_0004);
        @(negedge clk);
        check("disabled oe = DIR", gpio_oe, 32'h0000_000E);
        check("disabled o = OUT", gpio_o, 32'h0000_0005);

`ifdef GPIO_IRQ_EN
        bus_wr(8'h18, 32'h10);
        bus_wr(8'h10, 32'h10);
        check("irq idle", 32'(irq), 32'h0);
        gpio_i = 32'h0000_00B0;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            seen = (irq === 1'b1);
        end
        check("irq on rising edge", 32'(irq), 32'h1);
        bus_rd(8'h14, 32'h10);
        bus_wr(8'h14, 32'h10);
        @(negedge clk);
        check("irq after clear", 32'(irq), 32'h0);
        gpio_i = 32'h0000_00A0;
        repeat (6) @(negedge clk);
        check("irq falling edge ignored", 32'(irq), 32'h0);
        bus_rd(8'h14, 32'h0);
`else
        bus_wr(8'h10, 32'hFFFF_FFFF);
        bus_wr(8'h18, 32'hFFFF_FFFF);
        bus_wr(8'h1C, 32'hFFFF_FFFF);
        bus_rd(8'h10, 32'h0);
        bus_rd(8'h18, 32'h0);
        bus_rd(8'h1C, 32'h0);
        gpio_i = 32'h0000_00B0;
        repeat (6) @(negedge clk);
        check("irq tied low", 32'(irq), 32'h0);
        gpio_i = 32'h0000_00A0;
`endif

        // Readbacks, width masking, unmapped space, read+write collision
        bus_rd(8'h00, 32'h0000_000E);
        bus_rd(8'h04, 32'h0000_0005);
        bus_rd(8'h20, 32'd10);
        bus_wr(8'h24, 32'hFFFF_FFFF);
        bus_rd(8'h24, 32'h0000_FFFF);
        bus_wr(8'h34, 32'd7);
        bus_rd(8'h34, 32'h0);
        bus_wr(8'h60, 32'h1);
        bus_rd(8'h60, 32'h0);
        bus_rw(8'h04, 32'h0000_0007);
        bus_rd(8'h04, 32'h0000_0007);
        bus_wr(8'h0C, 32'hFF);
        bus_rd(8'h0C, 32'h0000_000F);
        bus_wr(8'h0C, 32'h0);

        // Reset in the middle of a running period
        bus_wr(8'h40, 32'd5);
        bus_wr(8'h0C, 32'h1);
        @(negedge clk);
        check("pwm high before reset", 32'(gpio_o[0]), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-period reset gpio_o", gpio_o, 32'h0);
        check("mid-period reset gpio_oe", gpio_oe, 32'h0);
        check("mid-period reset irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        bus_rd(8'h0C, 32'h0);
        bus_rd(8'h04, 32'h0);
        bus_rd(8'h40, 32'h0);

        repeat (3) @(negedge clk);
        check("responses outstanding", 32'(exp_data_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_pwm_ctrl.md
Name: gpio_pwm_ctrl

Overview:
Memory-mapped GPIO controller with a parametrised pin count and a parametrised number of PWM channels. Period and duty shadow registers update glitch-free at the end of each PWM period. Inputs pass through a synchroniser, and pins can raise edge interrupts. Sits on the core's simple read/write peripheral bus; the tristate pad buffers live outside this block.

Parameters:
WIDTH, 32, number of GPIO pins (1..32)
PWM_CH, 4, number of PWM channels (1..8); channel c drives pin c
PWM_W, 16, PWM counter/period/duty width (1..16)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
read  in  1  read strobe, single cycle
write  in  1  write strobe, single cycle
address  in  32  byte address; only [7:0] decoded
write_data  in  32  write data
read_data  out  32  read data, valid when response=1
response  out  1  one-cycle acknowledge
gpio_i  in  WIDTH  pad input values
gpio_o  out  WIDTH  pad output values
gpio_oe  out  WIDTH  pad output enables (1 = drive)
irq  out  1  level interrupt (tied 0 without GPIO_IRQ_EN)

Behaviour:
- Reset is synchronous, active-low. The following all clear to 0: every register, read_data, response, gpio_o, gpio_oe, irq, counters and synchroniser flops.
- Register map, word offsets:
  - 0x00 DIR (1 = output)
  - 0x04 OUT
  - 0x08 IN (read-only)
  - 0x0C PWM_EN[PWM_CH-1:0]
  - 0x10 IRQ_EN
  - 0x14 IRQ_STAT (write-1-to-clear)
  - 0x18 IRQ_EDGE: [WIDTH-1:0] rise enable; fall enable at offset 0x1C
  - 0x20+4c PERIOD[c]
  - 0x40+4c DUTY[c]
- Unmapped reads return 0. Unmapped writes are ignored but still acknowledged. Register bits above WIDTH or PWM_W read as 0.
- Bus handshake:
  - response=1 exactly one cycle after any read or write strobe.
  - read_data is registered and valid in that same cycle; it is 0 when response=0.
  - A write takes effect at the strobe edge.
  - If read and write are asserted together, the write wins and read_data=0.
- Input path: 2-flop synchroniser on gpio_i, giving IN = gpio_i delayed 2 clk.
- Pin muxing:
  - For pin p<PWM_CH with PWM_EN[p]=1: gpio_oe[p]=1, gpio_o[p]=pwm[p].
  - Otherwise: gpio_oe=DIR, gpio_o=OUT.
  - Outputs are registered: 1 cycle latency from a register write.
- PWM channel c:
  - Counter cnt runs 0..per_act-1, then wraps to 0.
  - Output pwm = (cnt < duty_act).
  - Writes to PERIOD/DUTY go to shadow registers. per_act/duty_act load from the shadows on the cycle cnt wraps to 0, or immediately if the channel is disabled or per_act==0.
  - per_act==0: cnt held at 0, pwm=0.
  - duty_act>=per_act: pwm constant 1. duty_act==0: pwm constant 0.
  - Clearing PWM_EN[c]: cnt is reset to 0. Setting it restarts the channel at cnt=0 with pwm high in the first cycle if duty>0.
- Reset mid-period aborts the period immediately, with all outputs forced to 0 the following cycle.

Optional Feature:
GPIO_IRQ_EN
- Defined:
  - Edge detector on the synchronised inputs.
  - IRQ_STAT[p] sets on a rising edge if rise[p]=1, and on a falling edge if fall[p]=1.
  - irq = |(IRQ_STAT & IRQ_EN), registered.
  - A write-1-to-clear in the same cycle as a new edge leaves the bit set (set wins).
- Undefined: offsets 0x10-0x1C read 0 and ignore writes; irq tied 0; no edge-detect logic synthesised.

Test Plan:
1. Reset, then read offsets 0x00-0x40 -> all return 0; response=1 one cycle after each read; gpio_oe=0, irq=0.
2. Write DIR=0x0000000F, OUT=0x5 -> gpio_oe=0xF, gpio_o=0x5 one cycle later. Drive gpio_i=0xA0 -> IN reads 0xA0 from the 3rd cycle onward.
3. Channel 0: PERIOD=10, DUTY=3, PWM_EN=1 -> pin 0 pattern is 3 high / 7 low, repeating every 10 clk, with gpio_oe[0]=1 regardless of DIR.
4. Write DUTY0=8 at cnt=5 -> current period keeps 3 high; next period shows 8 high / 2 low with no glitch. Then PERIOD=0 -> pin 0 held low.
5. DUTY=12 with PERIOD=10 -> constant 1. DUTY=0 -> constant 0. PWM_EN=0 -> pin reverts to DIR/OUT on the next cycle.
6. (GPIO_IRQ_EN) Set rise[4]=1, IRQ_EN[4]=1, toggle gpio_i[4] 0->1 -> irq=1 within 4 cycles. Write IRQ_STAT=0x10 -> irq=0. A falling edge alone does not set the bit.
